// File: rtl/bioee_adc_pkg.sv
// Shared definitions for the ADC framing path: FSM encoding, field widths,
// default sync byte and the header-word builder.
package bioee_adc_pkg;

  localparam int WORD_W = 16;
  localparam int SYNC_W = 8;
  localparam int SEQ_W  = 8;
  localparam int CNT_W  = 16;

  localparam logic [SYNC_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // State names describe the word currently presented on dout.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } pack_state_e;

  // Header word: sync marker in the upper byte, frame sequence number below.
  function automatic logic [WORD_W-1:0] make_header(input logic [SYNC_W-1:0] sync,
                                                    input logic [SEQ_W-1:0]  seq);
    return {sync, seq};
  endfunction

endpackage

// File: rtl/adc_sample_buf.sv
// Small first-word-fall-through sample FIFO. full/empty reflect the pointer
// state at the start of the cycle, so a same-cycle read never frees a slot
// for a same-cycle write.
module adc_sample_buf #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              do_wr_s;
  logic              do_rd_s;

  assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;
  assign dout    = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Pointer advance for accepted writes and reads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset flushes the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {(ADDR_W+1){1'b0}};
      rd_ptr_q <= {(ADDR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Frames buffered ADC samples as header / FRAME_LEN samples / checksum trailer
// for the SDRAM FIFO, stalling on fifo_full and counting buffer overflows.
module adc_frame_packer
  import bioee_adc_pkg::*;
#(
  parameter int unsigned       FRAME_LEN      = 256,
  parameter int unsigned       BUF_DEPTH_LOG2 = 4,
  parameter logic [SYNC_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              fifo_full,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic [WORD_W-1:0] overflow_count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  pack_state_e       state_q, state_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [WORD_W-1:0] overflow_q, overflow_d;
  logic              busy_q;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              abort_s;
  logic              rd_en_s;
  logic [WORD_W-1:0] header_s;
  logic [WORD_W-1:0] buf_dout_s;
  logic              buf_full_s;
  logic              buf_empty_s;

  adc_sample_buf #(
    .ADDR_W (int'(BUF_DEPTH_LOG2)),
    .DATA_W (WORD_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr_en (sample_valid),
    .rd_en (rd_en_s),
    .din   (sample_in),
    .dout  (buf_dout_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  // Framing FSM: picks the next word, advances checksum/count/sequence.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    seq_d        = seq_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    rd_en_s      = 1'b0;
    header_s     = make_header(SYNC_BYTE, seq_q);
    abort_s      = abort_q | ~enable;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (enable && !buf_empty_s && !fifo_full) begin
          dout_d       = header_s;
          dout_valid_d = 1'b1;
          csum_d       = header_s;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ST_HEADER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        // Once enable drops, the frame is finished off as aborted after draining.
        abort_d = abort_s;
        if (fifo_full) begin
          state_d = state_q;
        end else if ((cnt_q == FRAME_LEN_C) || (abort_s && buf_empty_s)) begin
          dout_d       = (cnt_q == FRAME_LEN_C) ? csum_q : ~csum_q;
          dout_valid_d = 1'b1;
          frame_done_d = 1'b1;
          seq_d        = seq_q + 8'd1;
          state_d      = ST_TRAILER;
        end else if (!buf_empty_s) begin
          rd_en_s      = 1'b1;
          dout_d       = buf_dout_s;
          dout_valid_d = 1'b1;
          csum_d       = csum_q + buf_dout_s;
          cnt_d        = cnt_q + 16'd1;
          state_d      = ST_PAYLOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_TRAILER: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating count of samples dropped because the buffer was already full.
  always_comb begin
    overflow_d = overflow_q;
    if (sample_valid && buf_full_s && (overflow_q != 16'hFFFF)) begin
      overflow_d = overflow_q + 16'd1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dout_q       <= 16'h0000;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 16'h0000;
      busy_q       <= 1'b0;
      seq_q        <= 8'h00;
      csum_q       <= 16'h0000;
      cnt_q        <= 16'h0000;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      busy_q       <= (state_d != ST_IDLE);
      seq_q        <= seq_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
    end
  end

  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign frame_done     = frame_done_q;
  assign overflow_count = overflow_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed scoreboard bench for adc_frame_packer with FRAME_LEN=4.
`timescale 1ns/1ps
module tb_adc_frame_packer;

  localparam int FL = 4;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        enable       = 1'b0;
  logic [15:0] sample_in    = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        fifo_full    = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        frame_done;
  logic [15:0] overflow_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int words_seen = 0;
  logic [16:0] exp_q [$];
  int vcyc_q [$];
  logic [7:0]  m_seq = 8'h00;
  logic [15:0] m_csum = 16'h0000;

  adc_frame_packer #(.FRAME_LEN(FL), .BUF_DEPTH_LOG2(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .dout(dout),
    .dout_valid(dout_valid), .frame_done(frame_done),
    .overflow_count(overflow_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every written word is popped from the scoreboard.
  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (dout_valid === 1'b1) begin
      words_seen++;
      vcyc_q.push_back(cyc);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word observed=%0h expected=none", dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout_word", 32'(dout), 32'(e[15:0]));
        chk("frame_done_with_word", 32'(frame_done), 32'(e[16]));
      end
    end else begin
      chk("frame_done_without_word", 32'(frame_done), 32'h0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic exp_header();
    logic [15:0] h;
    h = {8'hA5, m_seq};
    m_csum = h;
    exp_q.push_back({1'b0, h});
  endtask

  task automatic exp_sample(input logic [15:0] v);
    m_csum = m_csum + v;
    exp_q.push_back({1'b0, v});
  endtask

  task automatic exp_trailer(input bit aborted);
    exp_q.push_back({1'b1, aborted ? ~m_csum : m_csum});
    m_seq = m_seq + 8'd1;
  endtask

  task automatic send(input logic [15:0] v);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
  endtask

  task automatic quiet();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain observed=%0d expected=0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (words_seen < target && n < budget);
    checks++;
    assert (words_seen >= target) else begin
      errors++;
      $error("FAIL %s_words observed=%0d expected=%0d", tag, words_seen, target);
    end
  endtask

  initial begin
    int k;
    int w0;
    logic [15:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_overflow", 32'(overflow_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame: samples 1..4
    enable = 1'b1;
    exp_header();
    for (int i = 1; i <= 4; i++) exp_sample(16'(i));
    exp_trailer(1'b0);
    for (int i = 1; i <= 4; i++) send(16'(i));
    quiet();
    wait_drain("t1", 50);

    // Latency and back-to-back frames: 8 samples in a burst
    vcyc_q.delete();
    for (int f = 0; f < 2; f++) begin
      exp_header();
      for (int i = 0; i < 4; i++) exp_sample(16'h0011 + 16'(f * 4 + i));
      exp_trailer(1'b0);
    end
    send(16'h0011);
    k = cyc + 1;
    send(16'h0012);
    send(16'h0013);
    chk("busy_in_frame", 32'(busy), 32'h1);
    for (int i = 3; i < 8; i++) send(16'h0011 + 16'(i));
    quiet();
    wait_drain("b2b", 60);
    chk("b2b_word_count", 32'(vcyc_q.size()), 32'd12);
    for (int j = 0; j < 12; j++)
      chk("b2b_valid_cycle", 32'(vcyc_q[j]), 32'(k + 1 + j + ((j >= 6) ? 1 : 0)));
    chk("busy_after_frames", 32'(busy), 32'h0);

    // Five-cycle SDRAM stall in mid-payload
    exp_header();
    for (int i = 1; i <= 4; i++) exp_sample(16'h2000 + 16'(i));
    exp_trailer(1'b0);
    w0 = words_seen;
    for (int i = 1; i <= 4; i++) send(16'h2000 + 16'(i));
    quiet();
    wait_words("t2", w0 + 3, 30);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid_low", 32'(dout_valid), 32'h0);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("stall_resume", 32'(dout_valid), 32'h1);
    wait_drain("t2", 50);

    // Overflow: 20 samples while the SDRAM FIFO is full
    fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) send(16'h3000 + 16'(i));
    quiet();
    chk("ovf_count_4", 32'(overflow_count), 32'd4);
    chk("ovf_held_idle", 32'(busy), 32'h0);
    for (int f = 0; f < 4; f++) begin
      exp_header();
      for (int i = 0; i < 4; i++) exp_sample(16'h3000 + 16'(f * 4 + i));
      exp_trailer(1'b0);
    end
    fifo_full = 1'b0;
    wait_drain("t3", 100);

    // Enable dropped after two samples: aborted trailer
    exp_header();
    exp_sample(16'h0001);
    exp_sample(16'h0002);
    exp_trailer(1'b1);
    w0 = words_seen;
    send(16'h0001);
    send(16'h0002);
    quiet();
    wait_words("t4", w0 + 3, 30);
    enable = 1'b0;
    wait_drain("t4", 30);
    chk("abort_busy_idle", 32'(busy), 32'h0);

    // Reset in the middle of a payload
    enable = 1'b1;
    exp_header();
    for (int i = 1; i <= 4; i++) exp_sample(16'h6000 + 16'(i));
    exp_trailer(1'b0);
    w0 = words_seen;
    for (int i = 1; i <= 4; i++) send(16'h6000 + 16'(i));
    quiet();
    wait_words("t6", w0 + 2, 30);
    rst = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_dout_valid", 32'(dout_valid), 32'h0);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    chk("midrst_overflow", 32'(overflow_count), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    exp_q.delete();
    m_seq = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_no_output", 32'(dout_valid), 32'h0);
    exp_header();
    for (int i = 1; i <= 4; i++) exp_sample(16'h7000 + 16'(i));
    exp_trailer(1'b0);
    for (int i = 1; i <= 4; i++) send(16'h7000 + 16'(i));
    quiet();
    wait_drain("t6b", 50);

    // 257 frames: sequence number wraps FF -> 00
    for (int f = 0; f < 257; f++) begin
      exp_header();
      for (int i = 0; i < 4; i++) begin
        v = 16'($urandom_range(0, 65535));
        exp_sample(v);
        send(v);
      end
      exp_trailer(1'b0);
      quiet();
      wait_drain("t5", 40);
    end

    // Overflow counter saturation
    enable = 1'b0;
    @(negedge clk);
    sample_in    = 16'h5555;
    sample_valid = 1'b1;
    repeat (16 + 65534) @(negedge clk);
    chk("ovf_fffe", 32'(overflow_count), 32'h0000FFFE);
    @(negedge clk);
    chk("ovf_reach_ffff", 32'(overflow_count), 32'h0000FFFF);
    @(negedge clk);
    chk("ovf_saturate", 32'(overflow_count), 32'h0000FFFF);
    sample_valid = 1'b0;
    @(negedge clk);
    chk("sat_busy_idle", 32'(busy), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
